wb_trace_buffer: RTL and testbench

- Sits directly downstream of the CPU top: consumes its debug_wb_* writeback trace interface.
- Captures every architectural register write into an entry and buffers it in a synchronous FIFO.
- Drains entries through a valid/ready stream to a trace sink (UART/JTAG packer or on-board golden compare).
- Decouples the 1-per-cycle retire rate from a slower sink; overflow is reported, never stalls the CPU.

---
 rtl/wb_trace_defs.sv | 35 +++
 rtl/wb_trace_buffer_fifo.sv | 60 ++++++
 rtl/wb_trace_buffer.sv | 92 +++++++++
 tb/tb_wb_trace_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_defs.sv
// ============================================================================
// Module   : wb_trace_defs
// Brief    : Shared trace-entry width, field offsets and packing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_trace_defs;

   localparam int TRACE_ENTRY_WD  = 73;
   localparam int TRACE_PC_LSB    = 41;
   localparam int TRACE_WEN_LSB   = 37;
   localparam int TRACE_WNUM_LSB  = 32;
   localparam int TRACE_WDATA_LSB = 0;

   typedef logic [TRACE_ENTRY_WD-1:0] trace_entry_t;

   function automatic trace_entry_t pack_entry(
      input logic [31:0] pc,
      input logic [3:0]  wen,
      input logic [4:0]  wnum,
      input logic [31:0] wdata
   );
      trace_entry_t e;
      e = '0;
      e[TRACE_PC_LSB    +: 32] = pc;
      e[TRACE_WEN_LSB   +: 4]  = wen;
      e[TRACE_WNUM_LSB  +: 5]  = wnum;
      e[TRACE_WDATA_LSB +: 32] = wdata;
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_buffer_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word fall-through synchronous FIFO with wrap-bit pointers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
   import wb_trace_defs::*;
#(
   parameter int WIDTH  = TRACE_ENTRY_WD,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]  r_wr_ptr;
   logic [ADDR_W:0]  r_rd_ptr;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                  (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign count = r_wr_ptr - r_rd_ptr;
   assign dout  = r_mem[r_rd_ptr[ADDR_W-1:0]];

   // Guarded locally so a misbehaving caller can never corrupt the pointers.
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_one;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_one;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/wb_trace_buffer.sv
// ============================================================================
// Module   : wb_trace_buffer
// Brief    : Captures CPU writeback trace events into a FIFO drained by a
//            valid/ready sink; WB_TRACE_RETIRE_CNT_EN adds retire_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_trace_buffer
   import wb_trace_defs::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               debug_wb_pc,
   input  logic [3:0]                debug_wb_rf_wen,
   input  logic [4:0]                debug_wb_rf_wnum,
   input  logic [31:0]               debug_wb_rf_wdata,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [TRACE_ENTRY_WD-1:0] trace_data,
   output logic [ADDR_W:0]           fifo_count,
   output logic                      overflow
`ifdef WB_TRACE_RETIRE_CNT_EN
   ,
   output logic [31:0]               retire_cnt
`endif
);

   logic         w_push_req;
   logic         w_pop;
   logic         w_push;
   logic         w_empty;
   logic         w_full;
   trace_entry_t w_entry;
   logic         r_overflow;

   assign w_push_req = (debug_wb_rf_wen != 4'h0) && (debug_wb_rf_wnum != 5'd0);
   assign w_pop      = trace_valid && trace_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_entry    = pack_entry(debug_wb_pc, debug_wb_rf_wen,
                                  debug_wb_rf_wnum, debug_wb_rf_wdata);

   sync_fifo #(
      .WIDTH  (TRACE_ENTRY_WD),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (w_push),
      .pop    (w_pop),
      .din    (w_entry),
      .dout   (trace_data),
      .empty  (w_empty),
      .full   (w_full),
      .count  (fifo_count)
   );

   assign trace_valid = !w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_push_req && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;

`ifdef WB_TRACE_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   // Counts every capturable event, including the ones dropped on overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retire_cnt <= 32'd0;
      end else if (w_push_req) begin
         r_retire_cnt <= r_retire_cnt + 32'd1;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
// Randomized scoreboard bench for wb_trace_buffer against a queue-based model.
`default_nettype none

module tb_wb_trace_buffer;
   import wb_trace_defs::*;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic [31:0]               debug_wb_pc = '0;
   logic [3:0]                debug_wb_rf_wen = '0;
   logic [4:0]                debug_wb_rf_wnum = '0;
   logic [31:0]               debug_wb_rf_wdata = '0;
   logic                      trace_valid;
   logic                      trace_ready = 1'b0;
   logic [TRACE_ENTRY_WD-1:0] trace_data;
   logic [ADDR_W:0]           fifo_count;
   logic                      overflow;
`ifdef WB_TRACE_RETIRE_CNT_EN
   logic [31:0]               retire_cnt;
`endif

   wb_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .trace_valid       (trace_valid),
      .trace_ready       (trace_ready),
      .trace_data        (trace_data),
      .fifo_count        (fifo_count),
      .overflow          (overflow)
`ifdef WB_TRACE_RETIRE_CNT_EN
      ,
      .retire_cnt        (retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of captured entries in capture order.
   logic [72:0] exp_q[$];
   int          m_cnt = 0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_ret = '0;

   task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle: check DUT state against the model, drive inputs, advance the model.
   task automatic step(input logic [31:0] pc, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] wd, input logic rdy);
      bit req, p, acc;
      @(posedge clk); #2;
      chk("count",    73'(fifo_count),  73'(m_cnt));
      chk("valid",    73'(trace_valid), 73'(m_cnt != 0));
      chk("overflow", 73'(overflow),    73'(m_ovf));
`ifdef WB_TRACE_RETIRE_CNT_EN
      chk("retire_cnt", 73'(retire_cnt), 73'(m_ret));
`endif
      debug_wb_pc       = pc;
      debug_wb_rf_wen   = wen;
      debug_wb_rf_wnum  = wnum;
      debug_wb_rf_wdata = wd;
      trace_ready       = rdy;
      req = (wen != 4'h0) && (wnum != 5'd0);
      p   = (m_cnt > 0) && rdy;
      acc = req && ((m_cnt < DEPTH) || p);
      if (acc) exp_q.push_back({pc, wen, wnum, wd});
      if (req && !acc) m_ovf = 1'b1;
      m_cnt = m_cnt + int'(acc) - int'(p);
      if (req) m_ret = m_ret + 32'd1;
   endtask

   task automatic idle(input logic rdy);
      step(32'h0, 4'h0, 5'd0, 32'h0, rdy);
   endtask

   task automatic rand_write(input logic rdy);
      step($urandom, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)), $urandom, rdy);
   endtask

   task automatic drain();
      int n = 0;
      while (m_cnt > 0 && n < 4 * DEPTH) begin
         idle(1'b1);
         n++;
      end
      idle(1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset             = 1'b1;
      trace_ready       = 1'b0;
      debug_wb_pc       = $urandom;
      debug_wb_rf_wen   = 4'hF;
      debug_wb_rf_wnum  = 5'd7;
      debug_wb_rf_wdata = $urandom;
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_ret = '0;
      @(posedge clk); #2;
      chk("rst_valid",    73'(trace_valid), 73'(0));
      chk("rst_count",    73'(fifo_count),  73'(0));
      chk("rst_overflow", 73'(overflow),    73'(0));
      reset            = 1'b0;
      debug_wb_rf_wen  = 4'h0;
      debug_wb_rf_wnum = 5'd0;
   endtask

   // Monitor: compares every popped head against the scoreboard, and checks hold stability.
   bit          hold_prev = 1'b0;
   logic [72:0] hold_data = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_empty: got entry %h expected none (t=%0t)", trace_data, $time);
            end else begin
               chk("data", trace_data, exp_q.pop_front());
            end
         end
         if (hold_prev && !reset && trace_valid) chk("hold", trace_data, hold_data);
         hold_prev = !reset && trace_valid && !trace_ready;
         hold_data = trace_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Single write, held while the sink stalls.
      step(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678, 1'b0);
      idle(1'b0);
      chk("single_data", trace_data, {32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678});
      idle(1'b0);
      idle(1'b0);
      drain();

      // Filtered events: r0 write and a non-writing instruction.
      step($urandom, 4'hF, 5'd0, $urandom, 1'b0);
      step($urandom, 4'h0, 5'd3, $urandom, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Full with concurrent pop: accepted, no overflow.
      for (int i = 0; i < DEPTH; i++) rand_write(1'b0);
      rand_write(1'b1);
      idle(1'b0);
      drain();

      // Fill and overflow: 17th write dropped.
      for (int i = 0; i < DEPTH + 1; i++) rand_write(1'b0);
      idle(1'b0);
      idle(1'b0);
      drain();
      do_reset();

      // Wrap-around with toggling ready.
      for (int i = 0; i < 40; i++) rand_write(1'(i % 2));
      drain();

      // Reset mid-stream discards queued entries.
      for (int i = 0; i < 5; i++) rand_write(1'b0);
      do_reset();
      rand_write(1'b0);
      idle(1'b0);
      drain();

      // Random traffic including r0 writes, bubbles and backpressure.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0)
            step($urandom, 4'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 2) == 0));
         else
            idle(1'($urandom_range(0, 1)));
      end
      drain();
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
